rx_engine: RTL and testbench

UART receive engine: the receive counterpart of the serial transmit path, sitting between the asynchronous `rx` pin and the processor port bus. It synchronizes `rx`, detects and verifies start bits, and samples the data, optional parity and stop bits at mid-bit. Each completed frame is presented on `rx_data` with a ready flag and error flags. The processor clears the flags by reading port 0. Frame format uses the same Eight/Pen/OHEL controls and 4-bit baud select as the transmitter.

---
 rtl/rx_engine_if.sv | 21 ++
 rtl/rx_engine.sv | 156 +++++++++++++++
 tb/tb_rx_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_engine_if.sv
// Processor port bus for the UART receive engine.
// The processor is the master; the engine answers with data and status.
interface rx_engine_if;
    logic [15:0] port_id;
    logic        read_strobe;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        perr;
    logic        ferr;
    logic        ovf;

    modport master (
        output port_id, read_strobe,
        input  rx_data, rx_rdy, perr, ferr, ovf
    );

    modport slave (
        input  port_id, read_strobe,
        output rx_data, rx_rdy, perr, ferr, ovf
    );
endinterface

// File: rtl/rx_engine.sv
// UART receive engine: synchronizes rx, frames start/data/parity/stop at
// mid-bit and reports each byte with ready, parity, framing and overrun flags.
module rx_engine #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [3:0] baud_in,
    input  logic       Eight,
    input  logic       Pen,
    input  logic       OHEL,
    rx_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    function automatic logic [18:0] bt_of(input logic [3:0] b);
        logic [18:0] r;
        case (b)
            4'd0:    r = 19'(CLK_HZ / 300);
            4'd1:    r = 19'(CLK_HZ / 1200);
            4'd2:    r = 19'(CLK_HZ / 2400);
            4'd3:    r = 19'(CLK_HZ / 4800);
            4'd4:    r = 19'(CLK_HZ / 9600);
            4'd5:    r = 19'(CLK_HZ / 19200);
            4'd6:    r = 19'(CLK_HZ / 38400);
            4'd7:    r = 19'(CLK_HZ / 57600);
            4'd8:    r = 19'(CLK_HZ / 115200);
            4'd9:    r = 19'(CLK_HZ / 230400);
            4'd10:   r = 19'(CLK_HZ / 460800);
            default: r = 19'(CLK_HZ / 921600);
        endcase
        return r;
    endfunction

    state_t      state;
    logic        s1;
    logic        rxs;
    logic [18:0] cnt;
    logic [3:0]  idx;
    logic [8:0]  sh;
    logic [3:0]  cfg_baud;
    logic        cfg_eight;
    logic        cfg_pen;
    logic        cfg_ohel;

    logic [7:0]  data_q;
    logic        rdy_q;
    logic        perr_q;
    logic        ferr_q;
    logic        ovf_q;

    logic [18:0] bt;
    logic [18:0] hbt;
    logic [3:0]  nbits;
    logic [8:0]  aligned;
    logic [7:0]  data;
    logic        pbit;
    logic        par_err;
    logic        clr;

    // Frame bits enter at sh[8]; shorter frames are shifted down to bit 0.
    always_comb begin
        bt      = bt_of(cfg_baud);
        hbt     = bt >> 1;
        nbits   = 4'd7 + {3'b0, cfg_eight} + {3'b0, cfg_pen};
        aligned = sh >> (4'd9 - nbits);
        data    = cfg_eight ? aligned[7:0] : {1'b0, aligned[6:0]};
        pbit    = cfg_eight ? aligned[8] : aligned[7];
        par_err = cfg_pen && ((^data ^ cfg_ohel) != pbit);
        clr     = bus.read_strobe && (bus.port_id == 16'h0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s1        <= 1'b1;
            rxs       <= 1'b1;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            cfg_baud  <= '0;
            cfg_eight <= 1'b0;
            cfg_pen   <= 1'b0;
            cfg_ohel  <= 1'b0;
            data_q    <= 8'h00;
            rdy_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s1  <= rx;
            rxs <= s1;
            if (clr) begin
                rdy_q  <= 1'b0;
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        cfg_baud  <= baud_in;
                        cfg_eight <= Eight;
                        cfg_pen   <= Pen;
                        cfg_ohel  <= OHEL;
                        state     <= START;
                    end
                end
                START: begin
                    if (cnt == hbt - 19'd1) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 19'd1;
                    end
                end
                DATA: begin
                    if (cnt == bt - 19'd1) begin
                        cnt <= '0;
                        sh  <= {rxs, sh[8:1]};
                        idx <= idx + 4'd1;
                        if (idx == nbits - 4'd1)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 19'd1;
                    end
                end
                STOP: begin
                    if (cnt == bt - 19'd1) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        data_q <= data;
                        rdy_q  <= 1'b1;
                        perr_q <= par_err;
                        ferr_q <= !rxs;
                        // A read landing on completion clears overrun instead.
                        if (!clr && rdy_q)
                            ovf_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 19'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data = data_q;
    assign bus.rx_rdy  = rdy_q;
    assign bus.perr    = perr_q;
    assign bus.ferr    = ferr_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_rx_engine.sv
// Directed bench for rx_engine: frames driven bit-by-bit at 921600 baud
// (108 clocks per bit) with hand-computed expected bytes and flags.
module tb_rx_engine;
    localparam int BT = 108;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [3:0] baud_in;
    logic       Eight;
    logic       Pen;
    logic       OHEL;
    int         n_asrt = 0;
    int         n_fail = 0;

    rx_engine_if bus ();

    rx_engine #(.CLK_HZ(100_000_000)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .baud_in(baud_in),
        .Eight(Eight),
        .Pen(Pen),
        .OHEL(OHEL),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [8:0] payload, input int n,
                              input logic stop);
        rx = 1'b0;
        wait_cycles(BT);
        for (int i = 0; i < n; i++) begin
            rx = payload[i];
            wait_cycles(BT);
        end
        rx = stop;
        wait_cycles(BT);
        rx = 1'b1;
    endtask

    task automatic do_read(input logic [15:0] id);
        bus.port_id     = id;
        bus.read_strobe = 1'b1;
        wait_cycles(1);
        bus.read_strobe = 1'b0;
        bus.port_id     = 16'hFFFF;
    endtask

    initial begin
        reset           = 1'b1;
        rx              = 1'b1;
        baud_in         = 4'd11;
        Eight           = 1'b1;
        Pen             = 1'b0;
        OHEL            = 1'b0;
        bus.port_id     = 16'hFFFF;
        bus.read_strobe = 1'b0;
        wait_cycles(3);
        chk("reset_data", bus.rx_data, 8'h00);
        chk("reset_flags", {3'b0, bus.rx_rdy, bus.perr, bus.ferr, bus.ovf, 1'b0}, 8'h00);
        reset = 1'b0;
        wait_cycles(5);

        // 8N1 0xA5
        send_frame(9'h0A5, 8, 1'b1);
        chk("8n1_data", bus.rx_data, 8'hA5);
        chk("8n1_rdy", {7'b0, bus.rx_rdy}, 8'h01);
        chk("8n1_errs", {5'b0, bus.perr, bus.ferr, bus.ovf}, 8'h00);
        do_read(16'h0001);
        chk("other_port_rdy", {7'b0, bus.rx_rdy}, 8'h01);
        bus.port_id     = 16'h0000;
        bus.read_strobe = 1'b1;
        #1;
        chk("read_before_edge", {7'b0, bus.rx_rdy}, 8'h01);
        wait_cycles(1);
        bus.read_strobe = 1'b0;
        bus.port_id     = 16'hFFFF;
        chk("read_clear_rdy", {7'b0, bus.rx_rdy}, 8'h00);
        wait_cycles(20);

        // 7-bit with parity
        Eight = 1'b0;
        Pen   = 1'b1;
        OHEL  = 1'b0;
        send_frame({2'b00, 7'h41}, 8, 1'b1);
        chk("7e1_good_data", bus.rx_data, 8'h41);
        chk("7e1_good_perr", {7'b0, bus.perr}, 8'h00);
        send_frame({2'b01, 7'h41}, 8, 1'b1);
        chk("7e1_bad_perr", {7'b0, bus.perr}, 8'h01);
        OHEL = 1'b1;
        send_frame({2'b00, 7'h41}, 8, 1'b1);
        chk("7o1_p0_perr", {7'b0, bus.perr}, 8'h01);
        send_frame({2'b01, 7'h41}, 8, 1'b1);
        chk("7o1_p1_perr", {7'b0, bus.perr}, 8'h00);
        chk("7o1_p1_data", bus.rx_data, 8'h41);
        do_read(16'h0000);
        chk("7bit_ovf_cleared", {7'b0, bus.ovf}, 8'h00);

        // framing error
        Eight = 1'b1;
        Pen   = 1'b0;
        OHEL  = 1'b0;
        send_frame(9'h03C, 8, 1'b0);
        chk("ferr_flag", {7'b0, bus.ferr}, 8'h01);
        chk("ferr_rdy", {7'b0, bus.rx_rdy}, 8'h01);
        chk("ferr_data", bus.rx_data, 8'h3C);
        wait_cycles(300);
        do_read(16'h0000);
        chk("ferr_cleared", {6'b0, bus.rx_rdy, bus.ferr}, 8'h00);

        // false start
        rx = 1'b0;
        wait_cycles(20);
        rx = 1'b1;
        wait_cycles(300);
        chk("false_start_rdy", {7'b0, bus.rx_rdy}, 8'h00);
        chk("false_start_data", bus.rx_data, 8'h3C);
        send_frame(9'h055, 8, 1'b1);
        chk("after_false_data", bus.rx_data, 8'h55);
        chk("after_false_rdy", {7'b0, bus.rx_rdy}, 8'h01);
        do_read(16'h0000);
        wait_cycles(10);

        // overrun then read colliding with completion
        send_frame(9'h011, 8, 1'b1);
        send_frame(9'h022, 8, 1'b1);
        chk("ovf_data", bus.rx_data, 8'h22);
        chk("ovf_flag", {7'b0, bus.ovf}, 8'h01);
        fork
            send_frame(9'h033, 8, 1'b1);
            begin
                // completion edge is 1029 cycles after the start bit is driven
                repeat (1028) @(posedge clk);
                #1;
                bus.port_id     = 16'h0000;
                bus.read_strobe = 1'b1;
                @(posedge clk);
                #1;
                bus.read_strobe = 1'b0;
                bus.port_id     = 16'hFFFF;
            end
        join
        chk("collide_rdy", {7'b0, bus.rx_rdy}, 8'h01);
        chk("collide_ovf", {7'b0, bus.ovf}, 8'h00);
        chk("collide_data", bus.rx_data, 8'h33);
        do_read(16'h0000);
        wait_cycles(10);

        // config change mid-frame
        fork
            send_frame(9'h09A, 8, 1'b1);
            begin
                wait_cycles(300);
                baud_in = 4'd0;
                Eight   = 1'b0;
                Pen     = 1'b1;
            end
        join
        chk("latched_cfg_data", bus.rx_data, 8'h9A);
        chk("latched_cfg_flags", {4'b0, bus.rx_rdy, bus.perr, bus.ferr, bus.ovf}, 8'h08);
        baud_in = 4'd11;
        Eight   = 1'b1;
        Pen     = 1'b0;
        wait_cycles(10);

        // reset during DATA
        rx = 1'b0;
        wait_cycles(300);
        reset = 1'b1;
        rx    = 1'b1;
        wait_cycles(3);
        chk("midreset_data", bus.rx_data, 8'h00);
        chk("midreset_flags", {4'b0, bus.rx_rdy, bus.perr, bus.ferr, bus.ovf}, 8'h00);
        reset = 1'b0;
        wait_cycles(300);
        chk("post_reset_idle", {7'b0, bus.rx_rdy}, 8'h00);
        send_frame(9'h07E, 8, 1'b1);
        chk("post_reset_data", bus.rx_data, 8'h7E);
        chk("post_reset_flags", {4'b0, bus.rx_rdy, bus.perr, bus.ferr, bus.ovf}, 8'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
